music_player: RTL and testbench
===============================

Name: music_player

Overview:
- Reader side of the note-store RAM: fetches 5-bit note codes over the RAM read port (addrb/doutb) and plays them in sequence as a square-wave beep.
- Each note has a fixed duration, followed by a short silent gap.
- Sits between the note-store RAM and the buzzer pin; a loader on the RAM write port fills the song before start.

Parameters:
- DATA_WDTH, 5, note code width (matches RAM word).
- COL, 100, RAM depth in notes.
- COL_BITS, 8, address width.
- CLK_FREQ, 12_000_000, system clock in Hz; used for the half-period table.
- NOTE_TICKS, 3_000_000, clocks per note (250 ms).
- GAP_TICKS, 240_000, silent clocks after each note (20 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle play request.
- stop  in  1  one-cycle abort.
- song_len  in  COL_BITS  number of notes to play; sampled at start.
- wr_en  in  1  monitor of RAM W_EN; while high, the RAM does not update doutb.
- addrb  out  COL_BITS  RAM read address.
- doutb  in  DATA_WDTH  RAM read data; registered, valid one edge after addrb.
- busy  out  1  high from accepted start to end of play.
- done  out  1  one-cycle pulse at normal completion.
- cur_note  out  DATA_WDTH  code currently sounding; 0 when idle.
- beep  out  1  square-wave buzzer drive.

Behaviour:
- Reset (async, rst_n=0): state IDLE; addrb=0, busy=0, done=0, cur_note=0, beep=0; all counters cleared. All outputs are registered.
- Note codes:
  - 0 = rest: beep held 0 for the note duration.
  - 1-7 = C3..B3, 8-14 = C4..B4, 15-21 = C5..B5.
  - 22-30 = rest.
  - 31 = END marker.
- States: IDLE, FETCH, LATCH, PLAY, GAP, DONE.
- IDLE:
  - start=1 and stop=0: capture len = min(song_len, COL), set addrb=0, busy=1.
  - Then go to FETCH, or to DONE if len=0.
  - start while busy is ignored.
- FETCH: addrb is stable for one cycle; go to LATCH.
- LATCH:
  - If wr_en was high in the FETCH cycle, return to FETCH (retry; the read was blocked).
  - Otherwise capture cur_note=doutb.
  - If doutb=31, go to DONE (END consumes no time); else go to PLAY.
  - Latency from addrb change to capture: 2 clocks.
- PLAY:
  - Duration counter runs NOTE_TICKS cycles.
  - Tone counter toggles beep every HALF[cur_note] cycles; the first toggle is HALF cycles after PLAY entry, with beep starting at 0.
  - On expiry: beep=0, go to GAP.
- GAP: beep=0 for GAP_TICKS cycles. Then addrb+1; if addrb+1 == len go to DONE, else go to FETCH.
- DONE: one cycle; done=1, busy=0, cur_note=0, addrb=0; go to IDLE.
- stop:
  - In any non-IDLE state, the next edge gives IDLE, beep=0, busy=0, cur_note=0, addrb=0, and no done pulse.
  - If start and stop are asserted in the same cycle, stop wins.
- Width rules:
  - Duration counter is 24 bits and tone counter 16 bits.
  - HALF = CLK_FREQ/(2*f) rounded down; example: code 13 (A4, 440 Hz) gives 13636.
  - addrb never exceeds len-1; no wrap past COL-1.

Optional Feature:
- Macro MUSIC_LOOP_EN.
- Defined: at end of song (len reached or END code), pulse done for one cycle, keep busy=1, reset addrb to 0 and go to FETCH. Playback repeats until stop; len=0 behaves as without the macro.
- Undefined: single pass as specified above.

Decomposition:
- Package music_pkg holds:
  - NOTE_REST=0 and NOTE_END=31;
  - the state enum;
  - the 24-bit duration and 16-bit tone counter widths;
  - the function half_period(code, clk_freq) returning the table value, with 0 for rest codes.
- One sub-module, tone_gen: en, half_period in, beep out; clears and holds beep=0 when en=0 or half_period=0.

Test Plan:
- RAM[0..2]={13,0,31}, song_len=3, NOTE_TICKS=30000, GAP_TICKS=10, start -> addrb 0 then 1; first beep rise at PLAY+13636, beep toggles 2 times in note 0, rest note stays 0; done pulse after END with no PLAY for code 31; busy falls with done.
- song_len=0, start -> done pulse 1 clock later, addrb stays 0, beep never toggles.
- song_len=200 with RAM full of code 8, no END -> exactly 100 notes played (len clamped to COL), last addrb=99, then done.
- wr_en=1 during FETCH of note 1 -> LATCH retries FETCH, captured code matches RAM after wr_en drops, timing shifts by 2 clocks.
- stop mid-PLAY of note 5 -> next clock beep=0, busy=0, addrb=0, no done pulse; start and stop in the same cycle in IDLE -> stays IDLE.
- With MUSIC_LOOP_EN, RAM={8,31}, start -> done pulses every pass, addrb returns to 0, busy stays 1 until stop.

Source files
------------

// File: rtl/music_pkg.sv
// Shared constants, state encoding and note-period helper for the music player.
package music_pkg;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_END  = 5'd31;

  localparam int DUR_W  = 24;  // duration / gap counter width
  localparam int TONE_W = 16;  // tone half-period counter width

  // Player states, kept as plain constants so older tools and checkers can share them
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_PLAY  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Half period in clocks of the square wave for a note code; 0 for rest codes
  function automatic logic [TONE_W-1:0] half_period(input logic [4:0] code,
                                                     input int unsigned clk_freq);
    int unsigned f;
    case (code)
      5'd1:  f = 131;  5'd2:  f = 147;  5'd3:  f = 165;  5'd4:  f = 175;
      5'd5:  f = 196;  5'd6:  f = 220;  5'd7:  f = 247;
      5'd8:  f = 262;  5'd9:  f = 294;  5'd10: f = 330;  5'd11: f = 349;
      5'd12: f = 392;  5'd13: f = 440;  5'd14: f = 494;
      5'd15: f = 523;  5'd16: f = 587;  5'd17: f = 659;  5'd18: f = 698;
      5'd19: f = 784;  5'd20: f = 880;  5'd21: f = 988;
      default: f = 0;
    endcase
    if (f == 0 || code == NOTE_REST) half_period = '0;
    else half_period = TONE_W'(clk_freq / (2 * f));
  endfunction

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave generator: toggles beep every half_period clocks while enabled.
// beep is cleared and held low whenever en is low or half_period is zero.
module tone_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] half_period,
  output logic         beep
);

  logic [W-1:0] cnt;

  // Count clocks within a half period and flip beep at each boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else if (!en || half_period == '0) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else if (cnt == (half_period - W'(1))) begin
      cnt  <= '0;
      beep <= ~beep;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/music_player.sv
// Note-store reader: fetches note codes over the RAM read port and plays each
// as a square wave for a fixed duration followed by a silent gap.
// start/stop are single-cycle pulses; stop has priority over start.
// Optional build macro MUSIC_LOOP_EN: repeat the song until stop.
module music_player
  import music_pkg::*;
#(
  parameter int DATA_WDTH  = 5,
  parameter int COL        = 100,
  parameter int COL_BITS   = 8,
  parameter int CLK_FREQ   = 12_000_000,
  parameter int NOTE_TICKS = 3_000_000,
  parameter int GAP_TICKS  = 240_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [COL_BITS-1:0]  song_len,
  input  logic                 wr_en,
  output logic [COL_BITS-1:0]  addrb,
  input  logic [DATA_WDTH-1:0] doutb,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_WDTH-1:0] cur_note,
  output logic                 beep,
  output state_t               dbg_state
);

  state_t              state;
  logic [COL_BITS-1:0] len;
  logic [DUR_W-1:0]    dur;
  logic                wr_seen;  // RAM read was blocked during the FETCH cycle

  logic [TONE_W-1:0] half_tab [32];
  for (genvar g = 0; g < 32; g++) begin : g_half
    assign half_tab[g] = half_period(5'(g), int'(CLK_FREQ));
  end

  logic [COL_BITS-1:0] len_cap;
  logic [COL_BITS-1:0] addr_nxt;
  logic                play_last;
  logic                gap_last;
  logic                end_song;
  logic                tone_en;

  assign len_cap   = (song_len > COL_BITS'(COL)) ? COL_BITS'(COL) : song_len;
  assign addr_nxt  = addrb + COL_BITS'(1);
  assign play_last = (dur == DUR_W'(NOTE_TICKS - 1));
  assign gap_last  = (dur == DUR_W'(GAP_TICKS - 1));
  // Song ends on an END code at capture, or after the gap of the last note
  assign end_song  = ((state == ST_LATCH) && !wr_seen && (doutb == NOTE_END)) ||
                     ((state == ST_GAP) && gap_last && (addr_nxt == len));
  // Drop enable on the last PLAY cycle or on stop so beep is low on the next edge
  assign tone_en   = (state == ST_PLAY) && !play_last && !stop;
  assign dbg_state = state;

  tone_gen #(.W(TONE_W)) u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (tone_en),
    .half_period (half_tab[cur_note]),
    .beep        (beep)
  );

  // Playback sequencer: fetch, latch, play, gap, repeat until len or END
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len      <= '0;
      dur      <= '0;
      wr_seen  <= 1'b0;
      addrb    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_note <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != ST_IDLE) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        cur_note <= '0;
        addrb    <= '0;
        dur      <= '0;
        wr_seen  <= 1'b0;
      end else if (end_song) begin
        done     <= 1'b1;
        addrb    <= '0;
        cur_note <= '0;
        dur      <= '0;
`ifdef MUSIC_LOOP_EN
        state    <= ST_FETCH;
`else
        busy     <= 1'b0;
        state    <= ST_DONE;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              len   <= len_cap;
              addrb <= '0;
              dur   <= '0;
              if (len_cap == '0) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                busy  <= 1'b1;
                state <= ST_FETCH;
              end
            end
          end
          ST_FETCH: begin
            wr_seen <= wr_en;
            state   <= ST_LATCH;
          end
          ST_LATCH: begin
            if (wr_seen) begin
              state <= ST_FETCH;
            end else begin
              cur_note <= doutb;
              dur      <= '0;
              state    <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (play_last) begin
              dur   <= '0;
              state <= ST_GAP;
            end else begin
              dur <= dur + DUR_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_last) begin
              dur   <= '0;
              addrb <= addr_nxt;
              state <= ST_FETCH;
            end else begin
              dur <= dur + DUR_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player. Instance A uses the real clock frequency
// with a short note for tone timing; instance B uses tiny timings for long
// songs, read retry, stop and (with MUSIC_LOOP_EN) looping.
module tb_music_player;
  import music_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- instance A ----------------
  logic       a_start = 1'b0, a_stop = 1'b0, a_wr_en = 1'b0;
  logic [7:0] a_len = '0;
  logic [7:0] a_addrb;
  logic [4:0] a_doutb = '0;
  logic       a_busy, a_done, a_beep;
  logic [4:0] a_cur;
  state_t     a_dbg;
  logic [4:0] mem_a [256];

  music_player #(.NOTE_TICKS(30000), .GAP_TICKS(10)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .song_len(a_len),
    .wr_en(a_wr_en), .addrb(a_addrb), .doutb(a_doutb), .busy(a_busy),
    .done(a_done), .cur_note(a_cur), .beep(a_beep), .dbg_state(a_dbg)
  );

  always @(posedge clk) if (!a_wr_en) a_doutb <= mem_a[a_addrb];

  int   a_tog = 0;
  logic a_beep_q = 1'b0;
  always @(posedge clk) begin
    a_beep_q <= a_beep;
    if (a_beep !== a_beep_q) a_tog <= a_tog + 1;
  end

  // ---------------- instance B ----------------
  logic       b_start = 1'b0, b_stop = 1'b0, b_wr_en = 1'b0;
  logic [7:0] b_len = '0;
  logic [7:0] b_addrb;
  logic [4:0] b_doutb = '0;
  logic       b_busy, b_done, b_beep;
  logic [4:0] b_cur;
  state_t     b_dbg;
  logic [4:0] mem_b [256];

  music_player #(.CLK_FREQ(4000), .NOTE_TICKS(20), .GAP_TICKS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .song_len(b_len),
    .wr_en(b_wr_en), .addrb(b_addrb), .doutb(b_doutb), .busy(b_busy),
    .done(b_done), .cur_note(b_cur), .beep(b_beep), .dbg_state(b_dbg)
  );

  always @(posedge clk) if (!b_wr_en) b_doutb <= mem_b[b_addrb];

  int     b_plays = 0;
  int     b_dones = 0;
  logic [7:0] b_max = '0;
  state_t b_state_q = ST_IDLE;
  always @(posedge clk) begin
    b_state_q <= b_dbg;
    if (b_dbg == ST_PLAY && b_state_q != ST_PLAY) b_plays <= b_plays + 1;
    if (b_addrb > b_max) b_max <= b_addrb;
    if (b_done === 1'b1) b_dones <= b_dones + 1;
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int p0;
    int d0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 5'd0;
      mem_b[i] = 5'd0;
    end

    tick(3);
    check("rst_a_addrb", a_addrb, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_cur", a_cur, 0);
    check("rst_a_beep", a_beep, 0);
    check("rst_a_state", a_dbg, ST_IDLE);
    check("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;
    tick(1);

    // Song {13,0,31}: A4 tone, rest, END
    mem_a[0] = 5'd13; mem_a[1] = 5'd0; mem_a[2] = 5'd31;
    a_len = 8'd3; a_start = 1'b1;
    tick(1); a_start = 1'b0;
    check("s1_busy", a_busy, 1);
    check("s1_addrb0", a_addrb, 0);
    check("s1_fetch", a_dbg, ST_FETCH);
    tick(2);
    check("s1_cur13", a_cur, 13);
    check("s1_play", a_dbg, ST_PLAY);
    check("s1_beep_start", a_beep, 0);
    t0 = a_tog;
    tick(13635);
    check("s1_beep_before_rise", a_beep, 0);
    tick(1);
    check("s1_beep_rise", a_beep, 1);
    tick(13636);
    check("s1_beep_fall", a_beep, 0);
    tick(2728);
    check("s1_gap", a_dbg, ST_GAP);
    check("s1_toggles", a_tog - t0, 2);
    tick(10);
    check("s1_fetch1", a_dbg, ST_FETCH);
    check("s1_addrb1", a_addrb, 1);
    tick(2);
    check("s1_cur_rest", a_cur, 0);
    check("s1_play_rest", a_dbg, ST_PLAY);
    t0 = a_tog;
    tick(30000);
    check("s1_gap_rest", a_dbg, ST_GAP);
    check("s1_rest_silent", a_tog - t0, 0);
    tick(10);
    check("s1_addrb2", a_addrb, 2);
    tick(2);
    check("s1_done", a_done, 1);
    check("s1_done_state", a_dbg, ST_DONE);
    check("s1_busy_fall", a_busy, 0);
    check("s1_cur_clr", a_cur, 0);
    check("s1_addrb_clr", a_addrb, 0);
    tick(1);
    check("s1_done_pulse", a_done, 0);
    check("s1_idle", a_dbg, ST_IDLE);

    // song_len = 0
    t0 = a_tog;
    a_len = 8'd0; a_start = 1'b1;
    tick(1); a_start = 1'b0;
    check("s2_done", a_done, 1);
    check("s2_addrb", a_addrb, 0);
    check("s2_busy", a_busy, 0);
    tick(1);
    check("s2_done_pulse", a_done, 0);
    check("s2_idle", a_dbg, ST_IDLE);
    check("s2_no_beep", a_tog - t0, 0);

    // song_len = 200 clamps to 100 notes
    for (int i = 0; i < 256; i++) mem_b[i] = 5'd8;
    p0 = b_plays;
    b_len = 8'd200; b_start = 1'b1;
    tick(1); b_start = 1'b0;
    tick(2574);
    check("s3_addrb99", b_addrb, 99);
    check("s3_fetch99", b_dbg, ST_FETCH);
    tick(25);
    check("s3_gap99", b_dbg, ST_GAP);
    tick(1);
    check("s3_done", b_done, 1);
    check("s3_addrb_clr", b_addrb, 0);
    tick(2);
    check("s3_plays", b_plays - p0, 100);
    check("s3_max_addr", b_max, 99);

    // wr_en blocks the read of note 1
    mem_b[0] = 5'd5; mem_b[1] = 5'd9; mem_b[2] = 5'd31;
    b_len = 8'd3; b_start = 1'b1;
    tick(1); b_start = 1'b0;
    tick(26);
    check("s4_fetch1", b_dbg, ST_FETCH);
    check("s4_addrb1", b_addrb, 1);
    b_wr_en = 1'b1; mem_b[1] = 5'd12;
    tick(1);
    b_wr_en = 1'b0;
    tick(1);
    check("s4_retry", b_dbg, ST_FETCH);
    check("s4_retry_addrb", b_addrb, 1);
    tick(2);
    check("s4_cur12", b_cur, 12);
    check("s4_play", b_dbg, ST_PLAY);
    tick(24);
    check("s4_addrb2", b_addrb, 2);
    tick(2);
    check("s4_done_shift", b_done, 1);
    tick(1);

    // stop mid-PLAY of note 5
    for (int i = 0; i < 256; i++) mem_b[i] = 5'd13;
    b_len = 8'd10; b_start = 1'b1;
    tick(1); b_start = 1'b0;
    tick(137);
    check("s5_addrb5", b_addrb, 5);
    check("s5_play5", b_dbg, ST_PLAY);
    check("s5_beep_high", b_beep, 1);
    d0 = b_dones;
    b_stop = 1'b1;
    tick(1); b_stop = 1'b0;
    check("s5_idle", b_dbg, ST_IDLE);
    check("s5_beep", b_beep, 0);
    check("s5_busy", b_busy, 0);
    check("s5_addrb", b_addrb, 0);
    check("s5_cur", b_cur, 0);
    tick(5);
    check("s5_no_done", b_dones - d0, 0);
    b_start = 1'b1; b_stop = 1'b1;
    tick(1); b_start = 1'b0; b_stop = 1'b0;
    check("s5_ss_idle", b_dbg, ST_IDLE);
    check("s5_ss_busy", b_busy, 0);

`ifdef MUSIC_LOOP_EN
    // Looping song {8,31}
    mem_b[0] = 5'd8; mem_b[1] = 5'd31;
    b_len = 8'd5; b_start = 1'b1;
    tick(1); b_start = 1'b0;
    tick(28);
    check("s6_done1", b_done, 1);
    check("s6_busy1", b_busy, 1);
    check("s6_addrb1", b_addrb, 0);
    check("s6_fetch", b_dbg, ST_FETCH);
    tick(1);
    check("s6_done_pulse", b_done, 0);
    tick(27);
    check("s6_done2", b_done, 1);
    check("s6_busy2", b_busy, 1);
    b_stop = 1'b1;
    tick(1); b_stop = 1'b0;
    check("s6_stop_busy", b_busy, 0);
    check("s6_stop_idle", b_dbg, ST_IDLE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
